// File: rtl/poly_eval_pkg.sv
// poly_eval_pkg: shared types and helpers for the Horner polynomial sequencer.
//   state_t    - sequencer states (IDLE, ISSUE, WAIT, DONE)
//   *_DEF      - default degree and widths
//   sat_clamp  - clamps a wide signed sum into a bc-bit signed range; used by
//                poly_step when POLY_EVAL_SAT_EN is defined.
package poly_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int N_DEF  = 3;
  localparam int BC_DEF = 16;
  localparam int BT_DEF = 16;

  // Clamp a signed sum to [-2^(bc-1), 2^(bc-1)-1]; caller truncates to bc bits.
  function automatic logic signed [31:0] sat_clamp(input logic signed [32:0] sum,
                                                   input int bc);
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = (33'sd1 <<< (bc - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (bc - 1));
    if (sum > hi) begin
      return hi[31:0];
    end else if (sum < lo) begin
      return lo[31:0];
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/poly_eval_seq_if.sv
// poly_eval_seq_if: input and output handshakes of poly_eval_seq.
//   s_valid/s_ready/s_coef/s_t : request side (coefficients c_k at [k*BC +: BC], point t)
//   m_valid/m_ready/m_y/m_t    : result side (y and the t it was evaluated at)
// Modports: master = upstream/downstream environment, slave = the evaluator.
interface poly_eval_seq_if
  import poly_eval_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int BC = BC_DEF,
  parameter int BT = BT_DEF
);
  logic                  s_valid;
  logic                  s_ready;
  logic [(N+1)*BC-1:0]   s_coef;
  logic [BT-1:0]         s_t;
  logic                  m_valid;
  logic                  m_ready;
  logic [BC-1:0]         m_y;
  logic [BT-1:0]         m_t;

  modport master (
    output s_valid, s_coef, s_t, m_ready,
    input  s_ready, m_valid, m_y, m_t
  );

  modport slave (
    input  s_valid, s_coef, s_t, m_ready,
    output s_ready, m_valid, m_y, m_t
  );
endinterface

// File: rtl/poly_step.sv
// poly_step: two-stage multiply-quantize-add unit, r = c0 + floor(c1*t).
//   Stage 1 (en high): q = full signed c1*t with the redundant sign bit dropped
//                      and LSBs truncated; c0 is carried alongside.
//   Stage 2          : r = q + c0. Wraps modulo 2^BC, or saturates when the
//                      POLY_EVAL_SAT_EN macro is defined. Latency is 2 either way.
// Ports: clk, rst (sync, active high), en (issue strobe), c0, c1 (Q1.(BC-1)),
//        t (Q1.(BT-1)), r (registered result, held until the next step lands).
module poly_step
  import poly_eval_pkg::*;
#(
  parameter int BC = BC_DEF,
  parameter int BT = BT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [BC-1:0] c0,
  input  logic signed [BC-1:0] c1,
  input  logic signed [BT-1:0] t,
  output logic signed [BC-1:0] r
);

  logic signed [BC+BT-1:0] prod;
  logic signed [BC-1:0]    q_reg;
  logic signed [BC-1:0]    c0_reg;
  logic                    v1_reg;
  logic signed [BC-1:0]    r_reg;
  logic signed [BC-1:0]    r_next;

  assign prod = c1 * t;

`ifdef POLY_EVAL_SAT_EN
  logic signed [BC:0] sum_wide;
  always_comb begin
    sum_wide = {q_reg[BC-1], q_reg} + {c0_reg[BC-1], c0_reg};
    r_next   = BC'(sat_clamp(33'(sum_wide), BC));
  end
`else
  always_comb begin
    r_next = q_reg + c0_reg;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg  <= '0;
      c0_reg <= '0;
      v1_reg <= 1'b0;
      r_reg  <= '0;
    end else begin
      v1_reg <= en;
      if (en) begin
        // Low BC bits of prod >>> (BT-1) are exactly prod[BC+BT-2 -: BC] (floor).
        q_reg  <= BC'(prod >>> (BT - 1));
        c0_reg <= c0;
      end
      if (v1_reg) begin
        r_reg <= r_next;
      end
    end
  end

  assign r = r_reg;

endmodule

// File: rtl/poly_eval_seq.sv
// poly_eval_seq: evaluates y = c0 + c1*t + ... + cN*t^N by Horner's method using
// one shared poly_step unit, issuing N steps acc = c_k + acc*t.
// Ports: clk, rst (sync, active high), bus (poly_eval_seq_if.slave: request and
//        result handshakes), busy (high whenever the sequencer is not IDLE).
// Build option: POLY_EVAL_SAT_EN selects saturating instead of wrapping adds.
// Timing: accept at cycle 0, issues at 1,3,..,2N-1, m_valid at 2N+1.
module poly_eval_seq
  import poly_eval_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int BC = BC_DEF,
  parameter int BT = BT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  poly_eval_seq_if.slave   bus,
  output logic             busy
);

  // Wide enough to index all N+1 coefficients.
  localparam int KW = $clog2(N + 1);

  state_t                  state_reg, state_next;
  logic [KW-1:0]           k_reg, k_next;
  logic [(N+1)*BC-1:0]     coef_reg;
  logic signed [BT-1:0]    t_reg;
  logic signed [BC-1:0]    coef_arr [0:N];
  logic signed [BC-1:0]    acc;
  logic signed [BC-1:0]    step_r;
  logic                    issue;
  logic                    accept;

  for (genvar gi = 0; gi <= N; gi++) begin : g_coef
    assign coef_arr[gi] = coef_reg[gi*BC +: BC];
  end

  assign accept = (state_reg == IDLE) && bus.s_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      coef_reg  <= '0;
      t_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      if (accept) begin
        coef_reg <= bus.s_coef;
        t_reg    <= bus.s_t;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.s_valid) begin
          k_next     = KW'(N - 1);
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        issue      = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (k_reg == '0) begin
          state_next = DONE;
        end else begin
          k_next     = k_reg - 1'b1;
          state_next = ISSUE;
        end
      end
      DONE: begin
        if (bus.m_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The first step seeds the accumulator with c_N; later steps reuse the
  // previous result, which poly_step holds until its next write.
  assign acc = (k_reg == KW'(N - 1)) ? coef_arr[N] : step_r;

  poly_step #(
    .BC(BC),
    .BT(BT)
  ) u_step (
    .clk (clk),
    .rst (rst),
    .en  (issue),
    .c0  (coef_arr[k_reg]),
    .c1  (acc),
    .t   (t_reg),
    .r   (step_r)
  );

  assign bus.s_ready = (state_reg == IDLE);
  assign bus.m_valid = (state_reg == DONE);
  assign bus.m_y     = step_r;
  assign bus.m_t     = t_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_poly_eval_seq.sv
// tb_poly_eval_seq: directed checks of poly_eval_seq (N=3, Q1.15): reset state,
// constant term, Horner chain, overflow, backpressure, mid-op reset and
// back-to-back transactions against a floor-truncating Horner model.
module tb_poly_eval_seq;

  localparam int N  = 3;
  localparam int BC = 16;
  localparam int BT = 16;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  poly_eval_seq_if #(.N(N), .BC(BC), .BT(BT)) bus ();

  poly_eval_seq #(.N(N), .BC(BC), .BT(BT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Horner reference: q = floor(acc*t / 2^15) kept to 16 bits, then add c_k.
  function automatic logic [15:0] golden(input logic [63:0] coef, input logic [15:0] t);
    longint acc, p, q, s;
    logic [15:0] ck;
    acc = longint'($signed(coef[48 +: 16]));
    for (int k = N - 1; k >= 0; k--) begin
      p  = acc * longint'($signed(t));
      q  = p >>> 15;
      q  = longint'($signed(q[15:0]));
      ck = coef[k*16 +: 16];
      s  = q + longint'($signed(ck));
`ifdef POLY_EVAL_SAT_EN
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`else
      s = longint'($signed(s[15:0]));
`endif
      acc = s;
    end
    return acc[15:0];
  endfunction

  // Present a request and return just after the edge that accepted it.
  task automatic accept_txn(input string tag, input logic [63:0] coef, input logic [15:0] t);
    int n;
    bus.s_coef  = coef;
    bus.s_t     = t;
    bus.s_valid = 1'b1;
    n = 0;
    while (!bus.s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check({tag, "_accept_timeout"}, 32'(n), 32'd0);
    @(posedge clk); #1;
  endtask

  // Count cycles from accept (cycle 1 = first cycle after accept) to m_valid.
  task automatic wait_valid(input string tag, output int lat);
    lat = 1;
    while (!bus.m_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) check({tag, "_valid_timeout"}, 32'(lat), 32'd0);
  endtask

  task automatic run_txn(input string tag, input logic [63:0] coef, input logic [15:0] t,
                         input logic [15:0] exp_y);
    int lat;
    accept_txn(tag, coef, t);
    bus.s_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_s_ready_low"}, 32'(bus.s_ready), 32'd0);
    wait_valid(tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'(2*N + 1));
    check({tag, "_m_y"}, 32'(bus.m_y), 32'(exp_y));
    check({tag, "_m_t"}, 32'(bus.m_t), 32'(t));
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    check({tag, "_s_ready_after"}, 32'(bus.s_ready), 32'd1);
    check({tag, "_m_valid_after"}, 32'(bus.m_valid), 32'd0);
  endtask

  logic [63:0] vc [4];
  logic [15:0] vt [4];
  logic [15:0] vy [4];

  initial begin
    int lat;
    int seen;
    logic [15:0] ovf_exp;

    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    bus.s_coef  = '0;
    bus.s_t     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_y",     32'(bus.m_y),     32'd0);
    check("rst_m_t",     32'(bus.m_t),     32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: constant term only
    run_txn("const", {16'h0000, 16'h0000, 16'h0000, 16'h4000}, 16'h1234, 16'h4000);
    // 2: 0.5 * 0.5^3 = 0.0625
    run_txn("horner", {16'h4000, 16'h0000, 16'h0000, 16'h0000}, 16'h4000, 16'h0800);
    // 3: overflow in the first add
`ifdef POLY_EVAL_SAT_EN
    ovf_exp = 16'h7FFD;
`else
    ovf_exp = 16'hFFFD;
`endif
    run_txn("ovf", {16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000}, 16'h7FFF, ovf_exp);

    // 4: backpressure; c1=0.5, c0=0.125, t=0.25 -> 0.25
    accept_txn("bp", {16'h0000, 16'h0000, 16'h4000, 16'h1000}, 16'h2000);
    bus.s_valid = 1'b0;
    wait_valid("bp", lat);
    for (int i = 0; i < 10; i++) begin
      bus.s_valid = i[0];
      bus.s_coef  = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
      bus.s_t     = 16'h5555;
      check("bp_m_valid", 32'(bus.m_valid), 32'd1);
      check("bp_m_y",     32'(bus.m_y),     32'h2000);
      check("bp_m_t",     32'(bus.m_t),     32'h2000);
      check("bp_s_ready", 32'(bus.s_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    check("bp_s_ready_after", 32'(bus.s_ready), 32'd1);
    check("bp_m_valid_after", 32'(bus.m_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_idle_busy", 32'(busy), 32'd0);

    // 5: reset three cycles after accept
    accept_txn("rst_mid", {16'h4000, 16'h0000, 16'h0000, 16'h0000}, 16'h4000);
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_s_ready", 32'(bus.s_ready), 32'd1);
    check("rst_mid_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_mid_busy",    32'(busy),        32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.m_valid) seen++;
      @(posedge clk); #1;
    end
    check("rst_mid_no_spurious", 32'(seen), 32'd0);
    run_txn("post_rst", {16'h0000, 16'h0000, 16'h4000, 16'h0000}, 16'h4000, 16'h2000);

    // 6: back-to-back with s_valid held and m_ready high
    for (int i = 0; i < 4; i++) begin
      vc[i] = {$urandom(), $urandom()};
      vt[i] = 16'($urandom());
      vy[i] = golden(vc[i], vt[i]);
    end
    bus.m_ready = 1'b1;
    fork
      begin
        int prev;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
          accept_txn("b2b", vc[i], vt[i]);
          if (i > 0) check("b2b_gap", 32'(cyc - prev), 32'(2*N + 2));
          prev = cyc;
        end
        bus.s_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 4; j++) begin
          int n;
          n = 0;
          while (!bus.m_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
          end
          if (n >= 100) check("b2b_valid_timeout", 32'(n), 32'd0);
          check("b2b_m_y", 32'(bus.m_y), 32'(vy[j]));
          check("b2b_m_t", 32'(bus.m_t), 32'(vt[j]));
          @(posedge clk); #1;
        end
      end
    join
    bus.m_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/poly_eval_seq.md
Name: poly_eval_seq

Overview:
- Sequences a single pipelined multiply-accumulate stage to evaluate a degree-N fixed-point polynomial y = c0 + c1*t + … + cN*t^N by Horner's method.
- Accepts one coefficient vector plus t per transaction and issues N MAC steps, each computing acc = c_k + acc*t.
- Returns y on a valid/ready output.
- Sits between the waveform parameter path and the signal-generator datapath, replacing N parallel MACs with one shared stage.

Parameters:
- N, 3, polynomial degree; N >= 1 required.
- BC, 16, coefficient and result width, signed Q1.(BC-1).
- BT, 16, t width, signed Q1.(BT-1).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- s_valid  input  1  input transaction valid
- s_ready  output  1  block idle, can accept
- s_coef  input  (N+1)*BC  coefficients; c_k occupies bits [k*BC +: BC]
- s_t  input  BT  evaluation point
- m_valid  output  1  result valid
- m_ready  input  1  downstream accepts result
- m_y  output  BC  polynomial result
- m_t  output  BT  t echoed with its result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: s_ready=1, m_valid=0, m_y=0, m_t=0, busy=0. State is IDLE, step counter is 0, pipeline registers are 0.
- States:
  - IDLE: s_ready=1. On s_valid, latch s_coef and s_t, set acc=c_N, set k=N-1, go to ISSUE.
  - ISSUE: present c0=c_k, c1=acc, t to the step unit. Go to WAIT.
  - WAIT: one cycle. Step result is registered at the end of this cycle; acc takes the result.
    - If k==0, go to DONE.
    - Otherwise decrement k and go to ISSUE.
  - DONE: m_valid=1, m_y=acc, m_t=latched t. On m_ready, go to IDLE.
- Step unit:
  - Cycle 1: p = c1*t, a full BC+BT signed product. Register q = p[BC+BT-2 -: BC], i.e. drop the redundant sign bit and truncate the LSBs (floor).
  - Cycle 2: register r = q + c0, a BC-bit two's-complement wrap.
  - Latency is 2 cycles; the step unit is never issued while a step is in flight.
- Timing:
  - Accept at cycle 0. Issues occur at cycles 1, 3, …, 2N-1.
  - m_valid rises at cycle 2N+1 (7 for N=3).
  - Minimum transaction period is 2N+2 cycles; s_ready is low from cycle 1 until the cycle after the output handshake.
- Backpressure: while m_valid=1 and m_ready=0, m_y, m_t and m_valid hold stable and no new input is accepted.
- Input is ignored whenever s_ready=0. s_coef/s_t may change freely after acceptance.
- Reset mid-operation aborts the evaluation with no output, clears the pipeline, and returns to IDLE on the next cycle.
- m_valid never asserts spuriously after reset.

Optional Feature:
- Macro: POLY_EVAL_SAT_EN.
- Defined: the step-unit addition detects signed overflow and clamps to 2^(BC-1)-1 or -2^(BC-1).
- Undefined: the addition wraps modulo 2^BC.
- Latency is identical either way.

Decomposition:
- Package poly_eval_pkg: state enum (IDLE, ISSUE, WAIT, DONE), width localparams, and the saturate function used under the macro.
- One sub-module, poly_step, is natural: the 2-stage multiply-quantize-add unit with rst, clk, c0, c1, t, r.
- Sequencer FSM, coefficient/t holding registers and the k counter stay in poly_eval_seq.

Test Plan:
1. Constant term: N=3, c0=0x4000, others 0, t=0x1234 -> m_y=0x4000, m_t=0x1234, m_valid at cycle 7 after accept.
2. Horner chain: c3=0x4000, c2=c1=c0=0, t=0x4000 -> intermediate acc 0x2000, 0x1000, final m_y=0x0800.
3. Overflow, macro undefined: c3=c2=0x7FFF, c1=c0=0, t=0x7FFF -> m_y=0xFFFD. Same stimulus with POLY_EVAL_SAT_EN -> m_y=0x7FFD.
4. Backpressure: hold m_ready=0 for 10 cycles after m_valid -> m_y/m_t stable, s_ready=0, extra s_valid pulses ignored. One-cycle m_ready then completes the handshake and s_ready=1 the next cycle.
5. Reset mid-op: assert rst at cycle 3 after accept -> next cycle s_ready=1, m_valid=0, busy=0. A new transaction gives the correct result with no stale data.
6. Back-to-back: s_valid held high with m_ready=1 over 4 random vectors -> accepts spaced 8 cycles apart, results match the golden Horner model (floor-truncated Q1.15) in order.
